// File: rtl/rom_dn_router.sv
// Routes the ioctl download stream into NUM_REGIONS ROM/RAM regions and holds the core in reset until loaded.
// Optional per-region byte checksum output rom_csum is built when ROM_CHECKSUM_EN is defined.
module rom_dn_router #(
  parameter int                            NUM_REGIONS  = 4,
  parameter int                            ADDR_W       = 16,
  parameter int                            REGION_AW    = 13,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h5000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NUM_REGIONS*5-1:0]      REGION_LOG2  = {5'd11, 5'd12, 5'd12, 5'd13},
  parameter logic [7:0]                    DL_INDEX     = 8'd0,
  parameter int                            FLUSH_CYCLES = 16
) (
  input  logic                     clk_25,
  input  logic                     RESET_L,
  input  logic                     dn_download,
  input  logic [7:0]               dn_index,
  input  logic [ADDR_W-1:0]        dn_addr,
  input  logic [7:0]               dn_data,
  input  logic                     dn_wr,
  output logic [NUM_REGIONS-1:0]   rom_wr,
  output logic [REGION_AW-1:0]     rom_addr,
  output logic [7:0]               rom_data,
  output logic [NUM_REGIONS-1:0]   rom_loaded,
  output logic                     core_reset_l,
  output logic                     dl_busy,
  output logic [7:0]               err_cnt
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [8*NUM_REGIONS-1:0] rom_csum
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   busy_reg, busy_next;
  logic                   dl_prev_reg;

  logic                   index_ok;
  logic                   accept;
  logic                   dl_rise;
  logic                   start_load;

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] last;
  logic [REGION_AW-1:0]   offset [NUM_REGIONS];

  logic [NUM_REGIONS-1:0] sel;
  logic [REGION_AW-1:0]   sel_off;
  logic                   sel_last;
  logic                   found;

  logic [NUM_REGIONS-1:0] loaded_next;
  logic [7:0]             err_next;

  assign index_ok   = (dn_index == DL_INDEX);
  assign accept     = dn_wr & dn_download & index_ok;
  assign dl_rise    = dn_download & ~dl_prev_reg & index_ok;
  assign start_load = (state_reg == ST_IDLE) & dl_rise;

  // The subtraction wraps to a value above any region size when dn_addr is below the base,
  // so a single unsigned compare covers both bounds.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W-1:0] BASE = REGION_BASE[gi*ADDR_W +: ADDR_W];
      localparam int                LOG2 = int'(REGION_LOG2[gi*5 +: 5]);
      localparam logic [ADDR_W:0]   SIZE = (ADDR_W + 1)'(1) << LOG2;
      localparam logic [ADDR_W:0]   LAST = SIZE - (ADDR_W + 1)'(1);

      logic [ADDR_W:0] diff;
      assign diff        = {1'b0, dn_addr} - {1'b0, BASE};
      assign hit[gi]     = (diff < SIZE);
      assign last[gi]    = (diff == LAST);
      assign offset[gi]  = diff[REGION_AW-1:0];
    end
  endgenerate

  always_comb begin
    sel      = '0;
    sel_off  = '0;
    sel_last = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit[i] && !found) begin
        found    = 1'b1;
        sel[i]   = 1'b1;
        sel_off  = offset[i];
        sel_last = last[i];
      end
    end
  end

  always_comb begin
    loaded_next = start_load ? '0 : rom_loaded;
    if (accept && found && sel_last) begin
      loaded_next = loaded_next | sel;
    end
    err_next = start_load ? 8'd0 : err_cnt;
    if (accept && !found && err_next != 8'hFF) begin
      err_next = err_next + 8'd1;
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      rom_wr     <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      rom_loaded <= '0;
      err_cnt    <= '0;
    end else begin
      rom_wr     <= accept ? sel : '0;
      if (accept && found) begin
        rom_addr <= sel_off;
        rom_data <= dn_data;
      end
      rom_loaded <= loaded_next;
      err_cnt    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dl_rise) begin
          state_next = ST_LOADING;
          busy_next  = 1'b1;
        end
      end
      ST_LOADING: begin
        if (!dn_download) begin
          state_next = ST_FLUSH;
          cnt_next   = CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (dl_rise) begin
          state_next = ST_LOADING;
          busy_next  = 1'b1;
        end else if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else begin
          cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Reset parks the FSM in FLUSH so the core sees a full flush delay after power-up,
  // while dl_busy stays low because no download has happened.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_reg   <= ST_FLUSH;
      cnt_reg     <= CNT_W'(FLUSH_CYCLES);
      busy_reg    <= 1'b0;
      dl_prev_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      dl_prev_reg <= dn_download;
    end
  end

  assign core_reset_l = (state_reg == ST_IDLE);
  assign dl_busy      = busy_reg;

`ifdef ROM_CHECKSUM_EN
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_csum
      logic [7:0] sum_reg;
      logic [7:0] sum_base;
      logic [7:0] sum_add;

      assign sum_base = start_load ? 8'd0 : sum_reg;
      assign sum_add  = (accept && sel[gi]) ? dn_data : 8'd0;

      always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
          sum_reg <= '0;
        end else begin
          sum_reg <= sum_base + sum_add;
        end
      end

      assign rom_csum[gi*8 +: 8] = sum_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rom_dn_router.sv
// Scoreboard bench for rom_dn_router: expected strobes are queued at drive time and matched on output.
module tb_rom_dn_router;

  logic        clk_25 = 1'b0;
  logic        RESET_L = 1'b0;
  logic        dn_download = 1'b0;
  logic [7:0]  dn_index = 8'd0;
  logic [15:0] dn_addr = 16'd0;
  logic [7:0]  dn_data = 8'd0;
  logic        dn_wr = 1'b0;
  logic [3:0]  rom_wr;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_loaded;
  logic        core_reset_l;
  logic        dl_busy;
  logic [7:0]  err_cnt;
`ifdef ROM_CHECKSUM_EN
  logic [31:0] rom_csum;
`endif

  rom_dn_router dut (
    .clk_25       (clk_25),
    .RESET_L      (RESET_L),
    .dn_download  (dn_download),
    .dn_index     (dn_index),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .dn_wr        (dn_wr),
    .rom_wr       (rom_wr),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_loaded   (rom_loaded),
    .core_reset_l (core_reset_l),
    .dl_busy      (dl_busy),
    .err_cnt      (err_cnt)
`ifdef ROM_CHECKSUM_EN
    ,
    .rom_csum     (rom_csum)
`endif
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    logic [3:0]  wr;
    logic [12:0] addr;
    logic [7:0]  data;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t mon_item;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_loaded = 4'd0;
  int         exp_err = 0;

  int tb_base [4] = '{32'h0000, 32'h2000, 32'h4000, 32'h5000};
  int tb_size [4] = '{8192, 4096, 4096, 2048};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_25) begin
    if (RESET_L && rom_wr != 4'd0) begin
      $display("txn rom_wr=%b rom_addr=0x%h rom_data=0x%h", rom_wr, rom_addr, rom_data);
      if (sb_q.size() == 0) begin
        check_val("unexpected_wr", 32'(rom_wr), 32'd0);
      end else begin
        mon_item = sb_q.pop_front();
        check_val("sb_wr", 32'(rom_wr), 32'(mon_item.wr));
        check_val("sb_addr", 32'(rom_addr), 32'(mon_item.addr));
        check_val("sb_data", 32'(rom_data), 32'(mon_item.data));
      end
    end
  end

  // Drives one write cycle; drop=1 lowers dn_download in the same cycle.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit drop);
    bit       acc;
    int       r;
    sb_item_t it;
    @(posedge clk_25);
    #1;
    if (drop) dn_download = 1'b0;
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    acc = dn_download && (dn_index == 8'd0);
    if (acc) begin
      r = -1;
      for (int i = 0; i < 4; i++) begin
        if (r < 0 && int'(a) >= tb_base[i] && int'(a) < tb_base[i] + tb_size[i]) r = i;
      end
      if (r >= 0) begin
        it.wr   = 4'(1 << r);
        it.addr = 13'(int'(a) - tb_base[r]);
        it.data = d;
        sb_q.push_back(it);
        if (int'(a) - tb_base[r] == tb_size[r] - 1) exp_loaded[r] = 1'b1;
      end else if (exp_err < 255) begin
        exp_err++;
      end
    end
    @(posedge clk_25);
    #1;
    dn_wr = 1'b0;
  endtask

  task automatic set_dl(input logic [7:0] idx, input logic lvl);
    @(posedge clk_25);
    #1;
    dn_index    = idx;
    dn_download = lvl;
  endtask

  task automatic count_low(input string tag, input int exp_n, input logic exp_busy);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_25);
      if (core_reset_l) break;
      n++;
      check_val({tag, "_busy"}, 32'(dl_busy), 32'(exp_busy));
    end
    check_val(tag, 32'(n), 32'(exp_n));
    check_val({tag, "_busy_after"}, 32'(dl_busy), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_25);
      if (core_reset_l) break;
    end
    check_val(tag, 32'(core_reset_l), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_25);
    #1;
    check_val("rst_core_reset_l", 32'(core_reset_l), 32'd0);
    check_val("rst_rom_wr", 32'(rom_wr), 32'd0);
    check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_val("rst_rom_data", 32'(rom_data), 32'd0);
    check_val("rst_rom_loaded", 32'(rom_loaded), 32'd0);
    check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_val("rst_dl_busy", 32'(dl_busy), 32'd0);
    RESET_L = 1'b1;
    count_low("post_reset_flush", 16, 1'b0);
    check_val("idle_err_cnt", 32'(err_cnt), 32'd0);
    check_val("idle_rom_loaded", 32'(rom_loaded), 32'd0);

    // Main download, index 0
    set_dl(8'd0, 1'b1);
    @(posedge clk_25);
    #1;
    check_val("loading_busy", 32'(dl_busy), 32'd1);
    check_val("loading_core_reset_l", 32'(core_reset_l), 32'd0);
    do_write(16'h2005, 8'hA5, 1'b0);
    check_val("lat_rom_wr", 32'(rom_wr), 32'h2);
    check_val("lat_rom_addr", 32'(rom_addr), 32'h0005);
    check_val("lat_rom_data", 32'(rom_data), 32'hA5);
    @(posedge clk_25);
    #1;
    check_val("pulse_end_rom_wr", 32'(rom_wr), 32'd0);
    check_val("hold_rom_data", 32'(rom_data), 32'hA5);
    do_write(16'h0000, 8'h11, 1'b0);
    do_write(16'h1FFF, 8'h22, 1'b0);
    do_write(16'h4ABC, 8'h33, 1'b0);
    do_write(16'h3000, 8'h44, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_write(16'($urandom_range(32'h57FF, 0)), 8'($urandom_range(255, 0)), 1'b0);
    end
    do_write(16'h57FF, 8'h55, 1'b0);
    check_val("loaded_after_writes", 32'(rom_loaded), 32'(exp_loaded));
    check_val("err_after_writes", 32'(err_cnt), 32'(exp_err));
    check_val("loaded3_set", 32'(rom_loaded[3]), 32'd1);
    // Write in the same cycle download falls is ignored.
    do_write(16'h2000, 8'h77, 1'b1);
    count_low("dl_fall_flush", 16, 1'b1);
    check_val("loaded_retained", 32'(rom_loaded), 32'(exp_loaded));

    // Non-matching index
    set_dl(8'd1, 1'b1);
    do_write(16'h2005, 8'h99, 1'b0);
    do_write(16'h9000, 8'h99, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      check_val("idx1_core_reset_l", 32'(core_reset_l), 32'd1);
      check_val("idx1_busy", 32'(dl_busy), 32'd0);
    end
    check_val("idx1_loaded_kept", 32'(rom_loaded), 32'(exp_loaded));
    set_dl(8'd1, 1'b0);

    // Unmapped writes saturate err_cnt; entry clears loaded and err.
    set_dl(8'd0, 1'b1);
    exp_loaded = 4'd0;
    exp_err    = 0;
    @(posedge clk_25);
    #1;
    check_val("entry_clear_loaded", 32'(rom_loaded), 32'd0);
    check_val("entry_clear_err", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      do_write(16'h9000, 8'(i), 1'b0);
    end
    check_val("err_saturate", 32'(err_cnt), 32'(exp_err));
    check_val("err_is_255", 32'(exp_err), 32'd255);
    set_dl(8'd0, 1'b0);
    wait_idle("unmapped_idle");

`ifdef ROM_CHECKSUM_EN
    set_dl(8'd0, 1'b1);
    exp_loaded = 4'd0;
    exp_err    = 0;
    do_write(16'h0000, 8'h01, 1'b0);
    #1;
    check_val("csum_r0_first", 32'(rom_csum[7:0]), 32'h01);
    do_write(16'h0001, 8'hFF, 1'b0);
    #1;
    check_val("csum_r0_wrap", 32'(rom_csum[7:0]), 32'h00);
    do_write(16'h2000, 8'h33, 1'b0);
    #1;
    check_val("csum_r1", 32'(rom_csum[15:8]), 32'h33);
    set_dl(8'd0, 1'b0);
    wait_idle("csum_idle");
`endif

    // FLUSH re-entry keeps rom_loaded.
    set_dl(8'd0, 1'b1);
    exp_loaded = 4'd0;
    exp_err    = 0;
    do_write(16'h1FFF, 8'h5A, 1'b0);
    set_dl(8'd0, 1'b0);
    repeat (3) @(posedge clk_25);
    #1;
    check_val("in_flush_busy", 32'(dl_busy), 32'd1);
    set_dl(8'd0, 1'b1);
    @(posedge clk_25);
    #1;
    check_val("reenter_busy", 32'(dl_busy), 32'd1);
    check_val("reenter_loaded", 32'(rom_loaded), 32'(exp_loaded));
    repeat (20) @(posedge clk_25);
    #1;
    check_val("reenter_still_loading", 32'(core_reset_l), 32'd0);

    // Asynchronous reset mid-download with a write in flight.
    do_write(16'h9000, 8'h00, 1'b0);
    check_val("pre_reset_err", 32'(err_cnt), 32'(exp_err));
    @(posedge clk_25);
    #1;
    dn_addr = 16'h2001;
    dn_data = 8'hEE;
    dn_wr   = 1'b1;
    #5;
    RESET_L = 1'b0;
    #1;
    check_val("async_rst_loaded", 32'(rom_loaded), 32'd0);
    check_val("async_rst_err", 32'(err_cnt), 32'd0);
    check_val("async_rst_core_reset_l", 32'(core_reset_l), 32'd0);
    check_val("async_rst_busy", 32'(dl_busy), 32'd0);
    check_val("async_rst_rom_wr", 32'(rom_wr), 32'd0);
    @(posedge clk_25);
    #1;
    dn_wr       = 1'b0;
    dn_download = 1'b0;
    exp_loaded  = 4'd0;
    exp_err     = 0;
    RESET_L     = 1'b1;
    wait_idle("post_async_idle");
    check_val("post_async_rom_wr", 32'(rom_wr), 32'd0);

    repeat (3) @(posedge clk_25);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
